eightbit_alu_sequencer: RTL
===========================

// Module: eightbit_alu_sequencer
// PURPOSE
//  Upstream control/datapath stage for the 8-bit ALU (ops ADD, NOT-B, AND, OR).
//  - Holds a small operand register file.
//  - Accepts one instruction per valid/ready handshake and drives registered a/b/s to the ALU.
//  - Captures f/ovf on the following cycle, writes f back to the register file and reports it.
//  - Keeps a sticky overflow flag.
// PARAMETERS
//  DATA_W  8  operand/result width; must match the ALU width.
//  NREGS   4  number of register-file entries.
//  AW      2  register address width; NREGS == 2**AW.
// PORTS
//  clk          in   1       single clock; all state updates on the rising edge.
//  rst          in   1       synchronous, active-high reset.
//  ld_valid     in   1       host load request.
//  ld_ready     out  1       high only in IDLE.
//  ld_addr      in   AW      load target register.
//  ld_data      in   DATA_W  load value.
//  instr_valid  in   1       instruction request.
//  instr_ready  out  1       high in IDLE when ld_valid==0.
//  instr_op     in   2       00 ADD, 01 NOT-B, 10 AND, 11 OR.
//  instr_ra     in   AW      source register for ALU operand a.
//  instr_rb     in   AW      source register for ALU operand b.
//  instr_rd     in   AW      destination register.
//  alu_a        out  DATA_W  registered operand a to the ALU.
//  alu_b        out  DATA_W  registered operand b to the ALU.
//  alu_s        out  2       registered op select to the ALU.
//  alu_f        in   DATA_W  combinational ALU result.
//  alu_ovf      in   1       combinational ALU overflow.
//  res_valid    out  1       one-cycle pulse: result available.
//  res_data     out  DATA_W  captured result; held until the next capture.
//  res_ovf      out  1       ovf of the last result; held until the next capture.
//  ovf_sticky   out  1       OR of all captured ovf since reset or clear.
//  ovf_clr      in   1       clears ovf_sticky.
//  dbg_addr     in   AW      debug read address.
//  dbg_data     out  DATA_W  combinational rf[dbg_addr].
// BEHAVIOUR
//  Reset: state IDLE; every rf entry 0; alu_a/alu_b/alu_s/res_data 0;
//   res_valid, res_ovf, ovf_sticky 0. rst overrides every other input.
//  FSM states:
//   - IDLE: ready outputs as defined under PORTS.
//     - ld_valid: rf[ld_addr] <= ld_data; stay in IDLE.
//     - else instr_valid: alu_a <= rf[ra], alu_b <= rf[rb], alu_s <= op; latch rd; -> EXEC.
//   - EXEC: ALU output settles combinationally. At the edge:
//     rf[rd] <= alu_f, res_data <= alu_f, res_ovf <= alu_ovf, ovf_sticky |= alu_ovf; -> DONE.
//   - DONE: res_valid=1 for this cycle only; both ready outputs low; -> IDLE.
//  Timing:
//   - Accept edge T -> ALU inputs stable in T+1 -> res_valid in T+2.
//   - Throughput: one instruction per 3 cycles.
//  Arithmetic: the ALU defines results; ADD wraps mod 2**DATA_W. This block does no arithmetic.
//  ld and instr in the same IDLE cycle: ld wins (instr_ready=0). The instruction is taken next
//   cycle and reads the new value.
//  ra==rd or rb==rd is legal: the operand is read at accept; the write occurs at the EXEC edge.
//  ld_valid/instr_valid outside IDLE: ignored, no state change. Requesters must hold requests
//   until ready.
//  ovf_clr with a set in EXEC on the same edge: the set wins (sticky=1).
//  rst in EXEC or DONE: operation aborted; no rf writeback; res_valid stays 0.
//  alu_a/alu_b/alu_s hold their values outside accept edges.
// STRUCTURE
//  Shared package eightbit_alu_pkg:
//   - op localparams OP_ADD=2'b00, OP_NOTB=2'b01, OP_AND=2'b10, OP_OR=2'b11.
//   - FSM state encodings IDLE/EXEC/DONE; DATA_W default.
//  Sub-module alu_regfile:
//   - NREGS x DATA_W; two combinational read ports plus dbg port; one synchronous write port
//     with sync reset clear.
//   - The parent muxes the write source: ld in IDLE, alu_f in EXEC.
//  The ALU itself is instantiated only in the bench/top; it is not inside this block.
// TESTING (bench instantiates this block plus the 8-bit ALU)
//  1 ld r0=0x07, r1=0x64; ADD rd=r2 -> alu_a=0x07 alu_b=0x64 alu_s=00; res_data=0x6B res_ovf=0;
//    dbg r2=0x6B.
//  2 ld r0=0x50, r1=0x5A; ADD r3 -> res_data=0xAA res_ovf=1 ovf_sticky=1.
//    Then ovf_clr -> ovf_sticky=0.
//  3 r1=0x5A; NOT-B r2 -> 0xA5. r0=0x8F, r1=0x95: AND -> 0x85, OR -> 0x9F; res_ovf=0 for each.
//  4 instr_valid held high for 3 instructions -> accepts 3 cycles apart; res_valid one cycle each;
//    instr_ready=0 in EXEC/DONE.
//  5 ld_valid and instr_valid together in IDLE (ld r0=0x01, ADD r0+r0->r1) -> ld written first;
//    instr accepted next cycle; r1=0x02.
//  6 rst asserted during EXEC -> next cycle: IDLE, all rf=0, res_valid never pulses, outputs 0.

Source files
------------

// File: rtl/eightbit_alu_pkg.sv
// Shared definitions for the 8-bit ALU sequencer: ALU op codes, FSM states, default sizes.
package eightbit_alu_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_AW     = 2;
  localparam int DEF_NREGS  = 4;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_NOTB = 2'b01;
  localparam logic [1:0] OP_AND  = 2'b10;
  localparam logic [1:0] OP_OR   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/eightbit_alu_sequencer_if.sv
// Host-side bus of the ALU sequencer: register load, instruction issue and result report.
interface eightbit_alu_sequencer_if #(
  parameter int DATA_W = 8,
  parameter int AW     = 2
);
  logic              ld_valid;
  logic              ld_ready;
  logic [AW-1:0]     ld_addr;
  logic [DATA_W-1:0] ld_data;

  logic              instr_valid;
  logic              instr_ready;
  logic [1:0]        instr_op;
  logic [AW-1:0]     instr_ra;
  logic [AW-1:0]     instr_rb;
  logic [AW-1:0]     instr_rd;

  logic              res_valid;
  logic [DATA_W-1:0] res_data;
  logic              res_ovf;

  modport master (
    output ld_valid, ld_addr, ld_data,
    output instr_valid, instr_op, instr_ra, instr_rb, instr_rd,
    input  ld_ready, instr_ready, res_valid, res_data, res_ovf
  );

  modport slave (
    input  ld_valid, ld_addr, ld_data,
    input  instr_valid, instr_op, instr_ra, instr_rb, instr_rd,
    output ld_ready, instr_ready, res_valid, res_data, res_ovf
  );
endinterface

// File: rtl/eightbit_alu_sequencer_regfile.sv
// Operand register file: two combinational operand reads, one debug read,
// one synchronous write port, cleared by synchronous reset.
module alu_regfile #(
  parameter int DATA_W = 8,
  parameter int NREGS  = 4,
  parameter int AW     = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_a_i,
  output logic [DATA_W-1:0] rdata_a_o,
  input  logic [AW-1:0]     raddr_b_i,
  output logic [DATA_W-1:0] rdata_b_o,
  input  logic [AW-1:0]     dbg_addr_i,
  output logic [DATA_W-1:0] dbg_data_o
);

  logic [DATA_W-1:0] rf_q [NREGS];

  // Storage update: clear on reset, otherwise single-entry write.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREGS; i++) begin
        rf_q[i] <= {DATA_W{1'b0}};
      end
    end else if (we_i) begin
      rf_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o  = rf_q[raddr_a_i];
  assign rdata_b_o  = rf_q[raddr_b_i];
  assign dbg_data_o = rf_q[dbg_addr_i];

endmodule

// File: rtl/eightbit_alu_sequencer.sv
// Control/datapath stage feeding an external 8-bit ALU: issues one instruction
// per handshake, captures the ALU result a cycle later, writes it back and reports it.
module eightbit_alu_sequencer
  import eightbit_alu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NREGS  = DEF_NREGS,
  parameter int AW     = DEF_AW
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  eightbit_alu_sequencer_if.slave   host_if,
  output logic [DATA_W-1:0]         alu_a_o,
  output logic [DATA_W-1:0]         alu_b_o,
  output logic [1:0]                alu_s_o,
  input  logic [DATA_W-1:0]         alu_f_i,
  input  logic                      alu_ovf_i,
  output logic                      ovf_sticky_o,
  input  logic                      ovf_clr_i,
  input  logic [AW-1:0]             dbg_addr_i,
  output logic [DATA_W-1:0]         dbg_data_o
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] alu_a_q, alu_b_q, res_data_q;
  logic [1:0]        alu_s_q;
  logic [AW-1:0]     rd_q;
  logic              res_valid_q, res_ovf_q, sticky_q;

  logic              accept_s, capture_s, rf_we_s;
  logic [AW-1:0]     rf_waddr_s;
  logic [DATA_W-1:0] rf_wdata_s, rd_a_s, rd_b_s;

  alu_regfile #(.DATA_W(DATA_W), .NREGS(NREGS), .AW(AW)) u_rf (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .we_i       (rf_we_s),
    .waddr_i    (rf_waddr_s),
    .wdata_i    (rf_wdata_s),
    .raddr_a_i  (host_if.instr_ra),
    .rdata_a_o  (rd_a_s),
    .raddr_b_i  (host_if.instr_rb),
    .rdata_b_o  (rd_b_s),
    .dbg_addr_i (dbg_addr_i),
    .dbg_data_o (dbg_data_o)
  );

  // Loads take priority over instructions in IDLE; EXEC always writes back the ALU result.
  always_comb begin
    state_d    = state_q;
    accept_s   = 1'b0;
    capture_s  = 1'b0;
    rf_we_s    = 1'b0;
    rf_waddr_s = host_if.ld_addr;
    rf_wdata_s = host_if.ld_data;
    case (state_q)
      ST_IDLE: begin
        if (host_if.ld_valid) begin
          rf_we_s = 1'b1;
        end else if (host_if.instr_valid) begin
          accept_s = 1'b1;
          state_d  = ST_EXEC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        capture_s  = 1'b1;
        rf_we_s    = 1'b1;
        rf_waddr_s = rd_q;
        rf_wdata_s = alu_f_i;
        state_d    = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, ALU operand/select registers, result capture and sticky overflow (set beats clear).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      alu_a_q     <= {DATA_W{1'b0}};
      alu_b_q     <= {DATA_W{1'b0}};
      alu_s_q     <= 2'b00;
      rd_q        <= {AW{1'b0}};
      res_data_q  <= {DATA_W{1'b0}};
      res_ovf_q   <= 1'b0;
      res_valid_q <= 1'b0;
      sticky_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      res_valid_q <= capture_s;
      if (accept_s) begin
        alu_a_q <= rd_a_s;
        alu_b_q <= rd_b_s;
        alu_s_q <= host_if.instr_op;
        rd_q    <= host_if.instr_rd;
      end
      if (capture_s) begin
        res_data_q <= alu_f_i;
        res_ovf_q  <= alu_ovf_i;
      end
      if (capture_s && alu_ovf_i) begin
        sticky_q <= 1'b1;
      end else if (ovf_clr_i) begin
        sticky_q <= 1'b0;
      end
    end
  end

  assign host_if.ld_ready    = (state_q == ST_IDLE);
  assign host_if.instr_ready = (state_q == ST_IDLE) && !host_if.ld_valid;
  assign host_if.res_valid   = res_valid_q;
  assign host_if.res_data    = res_data_q;
  assign host_if.res_ovf     = res_ovf_q;
  assign alu_a_o             = alu_a_q;
  assign alu_b_o             = alu_b_q;
  assign alu_s_o             = alu_s_q;
  assign ovf_sticky_o        = sticky_q;

endmodule
